// File: rtl/nn_output_collector_pkg.sv
// Shared constants and types for the NN output collector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: Q2.14 constants, default widths/threshold, collector state
// encoding and entry-layout helpers.
package nn_collect_pkg;

  localparam int          DATA_W_DEF = 16;
  localparam int          DEPTH_DEF  = 16;
  localparam logic [15:0] ONE        = 16'h4000;  // 1.0 in Q2.14
  localparam logic [15:0] HALF       = 16'h2000;  // 0.5 in Q2.14
  localparam logic [15:0] THRESH_DEF = HALF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Entry layout, MSB first: {last, class[1:0], a3_1, a3_2}
  function automatic int entry_w(input int dw);
    return 2 * dw + 3;
  endfunction

  function automatic int last_ofs(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic int class_ofs(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/nn_output_collector_fifo.sv
// Synchronous FIFO with registered read port and occupancy count.
// Latency: write visible the cycle after the edge; pop data/valid one cycle after rd_en.
// Backpressure: writes refused when full unless a pop happens the same cycle (wr_ok low).
// Ports: clk/res; wr_en/wr_data/wr_ok write side; rd_en/rd_data/rd_valid read side;
// empty/full/count status.
module nn_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ok,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_ok;

  always_comb begin
    rd_ok      = rd_en && (count_q != '0);
    // When full, the slot being popped this cycle is the one being written.
    wr_ok      = wr_en && ((count_q != FULL_CNT) || rd_ok);
    wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d  = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_ok;
    count_d    = count_q;
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage needs no reset: contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);

endmodule

// File: rtl/nn_output_collector.sv
// Captures each new NN_CORE output pair (with class bits and last flag) into a FIFO for a reader.
// Latency: capture visible one cycle after the sampling edge; pops return data one cycle after rd_en.
// Backpressure: none toward NN_CORE; captures arriving while full are dropped and flagged in overflow.
// Ports: clk/res; a3_1/a3_2/finish_updating from core; capture_en arm; rd_en/rd_data/rd_valid
// read side; empty/full/count/overflow/done/sample_cnt status.
module nn_output_collector
  import nn_collect_pkg::*;
#(
  parameter int                 DATA_W = DATA_W_DEF,
  parameter int                 DEPTH  = DEPTH_DEF,
  parameter logic [DATA_W-1:0]  THRESH = THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [DATA_W-1:0]       a3_1,
  input  logic [DATA_W-1:0]       a3_2,
  input  logic                    finish_updating,
  input  logic                    capture_en,
  input  logic                    rd_en,
  output logic [2*DATA_W+2:0]     rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    done,
  output logic [31:0]             sample_cnt
);

  state_e                state_q, state_d;
  logic [2*DATA_W-1:0]   prev_q, prev_d, pair;
  logic                  prev_valid_q, prev_valid_d;
  logic                  finish_q;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic [31:0]           sample_cnt_q, sample_cnt_d;
  logic                  cap, last, wr_ok;
  logic [1:0]            cls;
  logic [2*DATA_W+2:0]   entry;

  // Capture decision and state sequencing.
  always_comb begin
    pair         = {a3_1, a3_2};
    cls          = {a3_1 >= THRESH, a3_2 >= THRESH};
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cap          = 1'b0;
    last         = 1'b0;
    if (!capture_en) begin
      state_d      = IDLE;
      prev_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = CAPTURE;
          prev_valid_d = 1'b0;
        end
        CAPTURE: begin
          // A finish edge captures even when the outputs did not move.
          if (finish_updating && !finish_q) begin
            cap     = 1'b1;
            last    = 1'b1;
            state_d = DRAIN;
          end else if (!prev_valid_q || (pair != prev_q)) begin
            cap = 1'b1;
          end
          if (cap) begin
            prev_d       = pair;
            prev_valid_d = 1'b1;
          end
        end
        DRAIN:   if (empty) state_d = DONE;
        default: state_d = DONE;
      endcase
    end
    entry  = {last, cls, pair};
    done_d = (state_d == DONE);
  end

  // Counters depend on whether the FIFO accepted the write.
  always_comb begin
    overflow_d   = overflow_q;
    sample_cnt_d = sample_cnt_q;
    if (capture_en && (state_q == IDLE)) sample_cnt_d = '0;
    if (cap && !wr_ok) overflow_d = 1'b1;
    if (wr_ok && (sample_cnt_q != '1)) sample_cnt_d = sample_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      finish_q     <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      finish_q     <= finish_updating;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  nn_sync_fifo #(
    .WIDTH (entry_w(DATA_W)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .res      (res),
    .wr_en    (cap),
    .wr_data  (entry),
    .wr_ok    (wr_ok),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  assign overflow   = overflow_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_nn_output_collector.sv
// Testbench for nn_output_collector: directed steps plus a random phase against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nn_output_collector;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [15:0] a3_1 = '0;
  logic [15:0] a3_2 = '0;
  logic        finish_updating = 1'b0;
  logic        capture_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [34:0] rd_data;
  logic        rd_valid, empty, full, overflow, done;
  logic [4:0]  count;
  logic [31:0] sample_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: behaviour expressed on a queue of entries.
  logic [34:0] mq[$];
  int          m_phase = 0;   // 0 disarmed, 1 collecting, 2 waiting for drain, 3 finished
  logic        m_prev_ok = 1'b0;
  logic [31:0] m_prev = '0;
  logic        m_fin = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [34:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0;

  localparam logic [15:0] TH = 16'h2000;

  always #5 clk = ~clk;

  nn_output_collector dut (
    .clk             (clk),
    .res             (res),
    .a3_1            (a3_1),
    .a3_2            (a3_2),
    .finish_updating (finish_updating),
    .capture_en      (capture_en),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overflow        (overflow),
    .done            (done),
    .sample_cnt      (sample_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic cap, last, was_empty, pop;
    cap = 1'b0;
    last = 1'b0;
    m_rd_valid = 1'b0;
    if (res) begin
      mq.delete();
      m_phase = 0; m_prev_ok = 1'b0; m_prev = '0; m_fin = 1'b0;
      m_ovf = 1'b0; m_done = 1'b0; m_cnt = '0; m_rd_data = '0;
      return;
    end
    was_empty = (mq.size() == 0);
    pop = rd_en && !was_empty;
    if (capture_en && m_phase == 1) begin
      if (finish_updating && !m_fin) begin cap = 1'b1; last = 1'b1; end
      else if (!m_prev_ok || {a3_1, a3_2} != m_prev) cap = 1'b1;
    end
    if (pop) begin
      m_rd_data = mq.pop_front();
      m_rd_valid = 1'b1;
    end
    if (cap) begin
      if (mq.size() < 16) begin
        mq.push_back({last, a3_1 >= TH, a3_2 >= TH, a3_1, a3_2});
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_ovf = 1'b1;
      end
      m_prev = {a3_1, a3_2};
      m_prev_ok = 1'b1;
    end
    if (!capture_en) begin
      m_phase = 0;
      m_prev_ok = 1'b0;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_prev_ok = 1'b0; m_cnt = '0; end
        1: if (last) m_phase = 2;
        2: if (was_empty) m_phase = 3;
        default: ;
      endcase
    end
    m_done = (m_phase == 3);
    m_fin = finish_updating;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == 16));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_done));
    chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
  endtask

  logic [15:0] vals [4] = '{16'h0000, 16'h1FFF, 16'h2000, 16'hFFFF};

  initial begin
    // Reset state
    step(); step();
    res = 1'b0;
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);

    // 1: held 0.5/0.5 gives exactly one entry
    res = 1'b1; capture_en = 1'b1; a3_1 = 16'h2000; a3_2 = 16'h2000;
    step();
    res = 1'b0;
    repeat (4) step();
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_sample_cnt", 64'(sample_cnt), 64'd1);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t1_entry", 64'(rd_data), 64'({1'b0, 2'b11, 16'h2000, 16'h2000}));
    chk("t1_rd_valid", 64'(rd_valid), 64'd1);
    step();
    chk("t1_pulse_end", 64'(rd_valid), 64'd0);

    // 2: repeated values do not capture
    a3_2 = 16'h0000;
    a3_1 = 16'h1000; step();
    a3_1 = 16'h1000; step();
    a3_1 = 16'h3000; step();
    a3_1 = 16'h3000; step();
    chk("t2_count", 64'(count), 64'd2);
    rd_en = 1'b1;
    step(); chk("t2_class0", 64'(rd_data[33:32]), 64'(2'b00));
    step(); chk("t2_class1", 64'(rd_data[33:32]), 64'(2'b10));
    rd_en = 1'b0;

    // 3: overfill, then drain in order
    capture_en = 1'b0; step();
    capture_en = 1'b1; step();
    for (int i = 0; i < 20; i++) begin
      a3_1 = 16'($urandom); a3_2 = 16'(i + 1); step();
    end
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_sample_cnt", 64'(sample_cnt), 64'd16);
    rd_en = 1'b1;
    repeat (16) step();
    step();
    chk("t3_empty_pop", 64'(rd_valid), 64'd0);
    rd_en = 1'b0;

    // 4: full FIFO, simultaneous write and read
    res = 1'b1; step(); res = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      a3_1 = 16'(i * 16'h0400); a3_2 = 16'($urandom); step();
    end
    a3_1 = 16'hABCD; rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t4_count", 64'(count), 64'd16);
    chk("t4_overflow", 64'(overflow), 64'd0);
    chk("t4_rd_valid", 64'(rd_valid), 64'd1);
    chk("t4_sample_cnt", 64'(sample_cnt), 64'd17);

    // 5: finish edge with unchanged outputs
    rd_en = 1'b1; repeat (16) step(); rd_en = 1'b0;
    a3_1 = 16'h3800; a3_2 = 16'h0400; step(); step();
    finish_updating = 1'b1; step();
    chk("t5_count", 64'(count), 64'd2);
    rd_en = 1'b1; step(); step(); rd_en = 1'b0;
    chk("t5_last_entry", 64'(rd_data), 64'({1'b1, 2'b10, 16'h3800, 16'h0400}));
    chk("t5_not_done_yet", 64'(done), 64'd0);
    step();
    chk("t5_done", 64'(done), 64'd1);
    capture_en = 1'b0; step();
    chk("t5_done_clear", 64'(done), 64'd0);
    finish_updating = 1'b0;

    // 6: reset mid-collection
    capture_en = 1'b1; step();
    for (int i = 0; i < 18; i++) begin
      a3_1 = 16'(i); a3_2 = 16'($urandom); step();
    end
    rd_en = 1'b1; repeat (11) step(); rd_en = 1'b0;
    chk("t6_count_pre", 64'(count), 64'd5);
    chk("t6_ovf_pre", 64'(overflow), 64'd1);
    res = 1'b1; step(); res = 1'b0;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_sample_cnt", 64'(sample_cnt), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      a3_1 = vals[$urandom_range(0, 3)];
      a3_2 = vals[$urandom_range(0, 3)];
      rd_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) finish_updating = ~finish_updating;
      capture_en = ($urandom_range(0, 30) != 0);
      res = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_output_collector.md
Name: nn_output_collector

Overview:
Read-side companion to NN_CORE. It watches the core's two output neurons (a3_1, a3_2) and its finish_updating flag during training or inference. It captures each new output pair into an internal FIFO, tagged with a thresholded class decision and a last-sample flag. A downstream reader (host bridge or LED/debug logic) drains the FIFO through a valid/read handshake.

Parameters:
DATA_W, 16, width of each NN output word (Q2.14, unsigned magnitude)
DEPTH, 16, FIFO entries; power of two, minimum 2
THRESH, 16'h2000, class threshold (0.5 in Q2.14); a3_i >= THRESH gives class bit 1

Ports:
clk  in  1  system clock, all logic rising-edge
res  in  1  synchronous, active-high reset
a3_1  in  DATA_W  NN_CORE output neuron 1
a3_2  in  DATA_W  NN_CORE output neuron 2
finish_updating  in  1  NN_CORE training-complete flag (level)
capture_en  in  1  arm collection; low forces IDLE
rd_en  in  1  reader pop request
rd_data  out  2*DATA_W+3  {last, class[1:0], a3_1, a3_2} of popped entry
rd_valid  out  1  one-cycle pulse, rd_data valid
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  log2(DEPTH)+1  entries held
overflow  out  1  sticky: a capture was dropped
done  out  1  finish seen and FIFO drained
sample_cnt  out  32  captures accepted since arm (saturating)

Behaviour:
- Reset: rd_data=0, rd_valid=0, empty=1, full=0, count=0, overflow=0, done=0, sample_cnt=0. FIFO pointers 0, prev-pair register 0, prev_valid=0, state IDLE.
- States:
  - IDLE: no captures. capture_en=1 -> CAPTURE; prev_valid cleared on entry.
  - CAPTURE: capture event when !prev_valid, or {a3_1,a3_2} != prev pair. On each event, prev pair <= inputs and prev_valid <= 1. A rising edge of finish_updating (registered previous value 0, current 1) forces a capture with last=1, even if outputs are unchanged, then -> DRAIN.
  - DRAIN: no captures. When empty=1 -> DONE.
  - DONE: done=1. Stays here until res or capture_en=0.
  - capture_en=0 in any state -> IDLE next cycle. FIFO contents and overflow are kept; done is cleared.
- Entry format: class[1] = (a3_1 >= THRESH) and class[0] = (a3_2 >= THRESH), unsigned compare. last=1 only on the finish capture.
- Write timing: capture sampled at edge N; entry visible (count++, empty=0) after edge N. sample_cnt increments on each accepted write and saturates at 2^32-1.
- Read: rd_en=1 with empty=0 at edge N pops the entry. rd_data is updated and rd_valid=1 for exactly the cycle after edge N. rd_data holds its value otherwise. rd_en with empty=1 is ignored: no pulse, no pointer change.
- Simultaneous read and write: both performed and count is unchanged. When full, a write is accepted only if a read occurs in the same cycle.
- Write while full with no read: entry dropped, overflow<=1 (sticky until res), sample_cnt not incremented. A dropped finish capture still moves the state to DRAIN.
- Pointers wrap modulo DEPTH. full = (count==DEPTH).
- res asserted mid-operation discards all FIFO contents at the next edge. No partial outputs.

Decomposition:
- Package nn_collect_pkg: DATA_W default, THRESH default, Q2.14 constants (ONE=16'h4000, HALF=16'h2000), state encoding (IDLE, CAPTURE, DRAIN, DONE), entry field offsets.
- One sub-module: nn_sync_fifo (parameterised width/depth, synchronous reset, registered read, count/full/empty). The top-level holds the FSM, change detect, classify and counters.

Test Plan:
1. res for 1 cycle, capture_en=1, a3_1=a3_2=16'h2000 held -> exactly 1 entry {0,2'b11,16'h2000,16'h2000}; sample_cnt=1; count=1.
2. a3_1 stepped 16'h1000, 16'h1000, 16'h3000, 16'h3000, a3_2=0 -> 2 entries after the first, classes 2'b00 then 2'b10; no entry for repeated values.
3. 20 distinct values with no reads (DEPTH=16) -> full=1, count=16, overflow=1, sample_cnt=16. Then 16 rd_en pulses -> data returned in order; rd_en on empty gives no rd_valid.
4. full FIFO, new value and rd_en in same cycle -> both occur, count stays 16, overflow unchanged.
5. finish_updating 0->1 with unchanged outputs 16'h3800/16'h0400 -> entry last=1, class=2'b10. State DRAIN; after all pops done=1. capture_en=0 -> done=0.
6. res asserted while count=5 and in CAPTURE -> next cycle count=0, empty=1, overflow=0, sample_cnt=0, state IDLE.
